// File: rtl/tone_generator.sv
// Square-wave sound-effect generator: plays half_period-divided tone for
// `duration` frame ticks, holds a silent gap, then pulses done.
module tone_generator #(
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             CLK_EN,
  input  logic             req,
  input  logic [DIV_W-1:0] half_period,
  input  logic [DUR_W-1:0] duration,
  output logic             busy,
  output logic             done,
  output logic             tone_out
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   hp_q, hp_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tone_q, tone_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic zero_req;
  assign zero_req = req && (half_period == '0 || duration == '0);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    div_d   = div_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (zero_req) begin
      state_d = IDLE;
      tone_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      div_d   = '0;
      dur_d   = '0;
      gap_d   = '0;
    end else if (req) begin
      // A request in any state (re)starts the tone; a coincident tick is dropped.
      state_d = PLAY;
      hp_d    = half_period;
      div_d   = half_period - 1'b1;
      dur_d   = duration;
      gap_d   = '0;
      tone_d  = 1'b1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (div_q == '0) begin
            tone_d = ~tone_q;
            div_d  = hp_q - 1'b1;
          end else begin
            div_d  = div_q - 1'b1;
          end
          if (CLK_EN) begin
            if (dur_q == DUR_W'(1)) begin
              tone_d = 1'b0;
              dur_d  = '0;
              div_d  = '0;
              if (GAP_TICKS > 0) begin
                state_d = GAP;
                gap_d   = GAP_W'(GAP_TICKS);
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else if (dur_q != '0) begin
              dur_d = dur_q - 1'b1;
            end
          end
        end
        GAP: begin
          tone_d = 1'b0;
          if (CLK_EN) begin
            if (gap_q == GAP_W'(1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              gap_d   = '0;
            end else if (gap_q != '0) begin
              gap_d = gap_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= IDLE;
      hp_q    <= '0;
      div_q   <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tone_out = tone_q;

endmodule

// File: tb/tb_tone_generator.sv
// Randomized and directed bench for tone_generator against a timing-level
// reference model (tone phase derived arithmetically from the start cycle).
module tb_tone_generator;
  localparam int GAP = 1;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        CLK_EN = 1'b0;
  logic        req = 1'b0;
  logic [15:0] half_period = '0;
  logic [5:0]  duration = '0;
  logic        busy, done, tone_out;

  tone_generator #(.DIV_W(16), .DUR_W(6), .GAP_TICKS(GAP)) dut (
    .CLK(CLK), .NRST(NRST), .CLK_EN(CLK_EN), .req(req),
    .half_period(half_period), .duration(duration),
    .busy(busy), .done(done), .tone_out(tone_out)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 playing, 2 silent gap.
  int cyc = 0;
  int m_mode = 0, m_start = 0, m_hp = 1, m_left = 0, m_gapl = 0;
  logic m_done = 1'b0;
  logic [2:0] exp_v;
  int en_cnt = 0;

  function automatic logic [2:0] expected();
    logic t;
    t = (m_mode == 1) && ((((cyc - m_start) / m_hp) % 2) == 0);
    return {m_mode != 0, m_done, t};
  endfunction

  task automatic model(input logic r, input int hp, input int dur, input logic en, input logic rst_n);
    cyc++;
    m_done = 1'b0;
    if (!rst_n) m_mode = 0;
    else if (r && (hp == 0 || dur == 0)) begin
      m_mode = 0; m_done = 1'b1;
    end else if (r) begin
      m_mode = 1; m_start = cyc; m_hp = hp; m_left = dur;
    end else if (m_mode == 1 && en) begin
      m_left--;
      if (m_left == 0) begin
        if (GAP > 0) begin m_mode = 2; m_gapl = GAP; end
        else begin m_mode = 0; m_done = 1'b1; end
      end
    end else if (m_mode == 2 && en) begin
      m_gapl--;
      if (m_gapl == 0) begin m_mode = 0; m_done = 1'b1; end
    end
    exp_v = expected();
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return #1 after.
  task automatic step(input logic r, input logic [15:0] hp, input logic [5:0] dur,
                      input logic en, input logic rst_n);
    req = r; half_period = hp; duration = dur; CLK_EN = en; NRST = rst_n;
    @(posedge CLK);
    model(r, hp, dur, en, rst_n);
    #1;
    req = 1'b0; CLK_EN = 1'b0; NRST = 1'b1;
  endtask

  // Periodic frame tick helper used by directed tests.
  function automatic logic tick(input int per);
    en_cnt++;
    return (en_cnt % per) == 0;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'd0, 6'd0, 1'b0, 1'b0);
      checks++;
      if ({busy, done, tone_out} !== 3'b000) begin
        failures++; $display("FAIL reset cyc=%0d got=%b want=000", i, {busy, done, tone_out});
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'($urandom), 6'($urandom), 1'b0, 1'b1);
      checks++;
      if ({busy, done, tone_out} !== 3'b000) begin
        failures++; $display("FAIL idle_after_reset cyc=%0d got=%b want=000", i, {busy, done, tone_out});
      end
    end
  endtask

  task automatic test_basic();
    int dones = 0;
    en_cnt = 0;
    step(1'b1, 16'd4, 6'd3, 1'b0, 1'b1);
    checks++;
    if ({busy, tone_out} !== 2'b11) begin
      failures++; $display("FAIL basic_start got=%b want=11", {busy, tone_out});
    end
    for (int i = 0; i < 180; i++) begin
      step(1'b0, 16'($urandom), 6'($urandom), tick(40), 1'b1);
      dones += done;
      checks++;
      if ({busy, done, tone_out} !== exp_v) begin
        failures++; $display("FAIL basic cyc=%0d got=%b want=%b", i, {busy, done, tone_out}, exp_v);
      end
    end
    checks++;
    if (dones != 1) begin
      failures++; $display("FAIL basic_done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_retrigger();
    int dones = 0;
    en_cnt = 0;
    step(1'b1, 16'd4, 6'd3, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (i == 50) step(1'b1, 16'd2, 6'd2, 1'b0, 1'b1);
      else step(1'b0, 16'd0, 6'd0, tick(40), 1'b1);
      dones += done;
      checks++;
      if ({busy, done, tone_out} !== exp_v) begin
        failures++; $display("FAIL retrigger cyc=%0d got=%b want=%b", i, {busy, done, tone_out}, exp_v);
      end
      if (i == 50) begin
        checks++;
        if ({busy, tone_out} !== 2'b11) begin
          failures++; $display("FAIL retrigger_restart got=%b want=11", {busy, tone_out});
        end
      end
    end
    checks++;
    if (dones != 1) begin
      failures++; $display("FAIL retrigger_done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_zero();
    step(1'b1, 16'd5, 6'd0, 1'b0, 1'b1);
    checks++;
    if ({busy, done, tone_out} !== 3'b010) begin
      failures++; $display("FAIL zero_idle got=%b want=010", {busy, done, tone_out});
    end
    step(1'b0, 16'd0, 6'd0, 1'b0, 1'b1);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL zero_idle_one_cycle got=%b want=0", done);
    end
    step(1'b1, 16'd3, 6'd4, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 16'd0, 6'd0, 1'b0, 1'b1);
    step(1'b1, 16'd0, 6'd4, 1'b0, 1'b1);
    checks++;
    if ({busy, done, tone_out} !== 3'b010) begin
      failures++; $display("FAIL zero_play got=%b want=010", {busy, done, tone_out});
    end
    step(1'b0, 16'd0, 6'd0, 1'b0, 1'b1);
    checks++;
    if ({busy, done, tone_out} !== 3'b000) begin
      failures++; $display("FAIL zero_play_after got=%b want=000", {busy, done, tone_out});
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 16'd6, 6'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 6'd0, 1'b1, 1'b0);
    checks++;
    if ({busy, done, tone_out} !== 3'b000) begin
      failures++; $display("FAIL reset_mid got=%b want=000", {busy, done, tone_out});
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 16'd0, 6'd0, (i % 5) == 0, 1'b1);
      checks++;
      if ({busy, done, tone_out} !== 3'b000) begin
        failures++; $display("FAIL reset_mid_quiet cyc=%0d got=%b want=000", i, {busy, done, tone_out});
      end
    end
  endtask

  task automatic test_collision();
    int ticks_seen = 0;
    int ticks_at_stop = -1;
    step(1'b1, 16'd3, 6'd2, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      logic en;
      en = (i % 10) == 9;
      step(1'b0, 16'd0, 6'd0, en, 1'b1);
      if (en) ticks_seen++;
      if (ticks_at_stop < 0 && !tone_out && busy && m_mode == 2) ticks_at_stop = ticks_seen;
      checks++;
      if ({busy, done, tone_out} !== exp_v) begin
        failures++; $display("FAIL collision cyc=%0d got=%b want=%b", i, {busy, done, tone_out}, exp_v);
      end
    end
    checks++;
    if (ticks_at_stop != 2) begin
      failures++; $display("FAIL collision_ticks got=%0d want=2", ticks_at_stop);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      logic r, en, rn;
      r  = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 499) != 0);
      step(r, 16'($urandom_range(0, 5)), 6'($urandom_range(0, 4)), en, rn);
      checks++;
      if ({busy, done, tone_out} !== exp_v) begin
        failures++; $display("FAIL random cyc=%0d got=%b want=%b", i, {busy, done, tone_out}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retrigger();
    test_zero();
    test_reset_mid();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
